// File: rtl/plot_pkg.sv
// Shared encodings and width helpers for the plot sequencer and its line issuer.
package plot_pkg;

  localparam int ST_W = 4;
  typedef logic [ST_W-1:0] state_t;

  localparam state_t S_IDLE      = 4'd0;
  localparam state_t S_AXES      = 4'd1;
  localparam state_t S_AXES_WAIT = 4'd2;
  localparam state_t S_PARSE     = 4'd3;
  localparam state_t S_PARSE_WAIT= 4'd4;
  localparam state_t S_EVAL      = 4'd5;
  localparam state_t S_EVAL_WAIT = 4'd6;
  localparam state_t S_SEG       = 4'd7;
  localparam state_t S_SEG_WAIT  = 4'd8;
  localparam state_t S_NEXT      = 4'd9;

  function automatic int x_width(input int hor);
    return (hor > 1) ? $clog2(hor) : 1;
  endfunction

  function automatic int y_width(input int ver);
    return (ver > 1) ? $clog2(ver) : 1;
  endfunction

  function automatic int ch_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  // Line request packs as {x1, y1, x2, y2}.
  function automatic int line_req_width(input int xw, input int yw);
    return 2 * xw + 2 * yw;
  endfunction

endpackage

// File: rtl/plot_line_issuer.sv
// Holds segment endpoints, pulses line_start and waits for the drawer to go idle.
module plot_line_issuer
  import plot_pkg::*;
#(
  parameter int XW = 10,
  parameter int YW = 9
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clear,
  input  logic                              req,
  input  logic [line_req_width(XW, YW)-1:0] req_line,
  input  logic                              line_ready,
  output logic                              line_start,
  output logic [XW-1:0]                     x1,
  output logic [YW-1:0]                     y1,
  output logic [XW-1:0]                     x2,
  output logic [YW-1:0]                     y2,
  output logic                              done
);

  logic busy;
  logic arm;

  // line_ready is ignored in the pulse cycle and the one after it.
  assign done = busy && !line_start && !arm && line_ready;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      line_start <= 1'b0;
      busy       <= 1'b0;
      arm        <= 1'b0;
      x1         <= '0;
      y1         <= '0;
      x2         <= '0;
      y2         <= '0;
    end else begin
      line_start <= 1'b0;
      arm        <= line_start;
      if (req && !busy) begin
        {x1, y1, x2, y2} <= req_line;
        line_start       <= 1'b1;
        busy             <= 1'b1;
      end else if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/plot_sequencer.sv
// Multi-channel plot controller: parse, sweep x through the evaluator, emit polylines.
// Define PLOT_SEQ_AXES_EN to draw the two axes once at the start of each run.
//
// state       | meaning
// IDLE        | ready for start
// AXES        | request horizontal (axis_sel=0) or vertical (axis_sel=1) axis line
// AXES_WAIT   | wait for axis line to finish
// PARSE       | parser_start pulse
// PARSE_WAIT  | wait for parser_ready
// EVAL        | eval_start pulse for current eval_x
// EVAL_WAIT   | wait for eval_ready, classify the sample
// SEG         | request segment prev -> current
// SEG_WAIT    | wait for segment line to finish
// NEXT        | advance x, then channel, then finish
module plot_sequencer
  import plot_pkg::*;
#(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 450,
  parameter int CHANNELS          = 2,
  parameter int X_STEP            = 1,
  parameter int AXIS_X            = 320,
  parameter int AXIS_Y            = 225,
  localparam int CW = ch_width(CHANNELS),
  localparam int XW = x_width(HOR_ACTIVE_PIXELS),
  localparam int YW = y_width(VER_ACTIVE_PIXELS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  output logic          ready,
  output logic [CW-1:0] channel,
  output logic          parser_start,
  input  logic          parser_ready,
  output logic          eval_start,
  input  logic          eval_ready,
  output logic [XW-1:0] eval_x,
  input  logic [YW-1:0] eval_y,
  input  logic          eval_skip,
  output logic [XW-1:0] x1,
  output logic [YW-1:0] y1,
  output logic [XW-1:0] x2,
  output logic [YW-1:0] y2,
  output logic          line_start,
  input  logic          line_ready
);

  localparam int RW = line_req_width(XW, YW);
  localparam logic [XW:0]   X_LAST  = (XW+1)'(HOR_ACTIVE_PIXELS - 1);
  localparam logic [XW:0]   X_INC   = (XW+1)'(X_STEP);
  localparam logic [CW-1:0] CH_LAST = CW'(CHANNELS - 1);

  state_t          state, state_nxt;
  logic            wait_arm;
  logic            have_prev;
  logic [XW-1:0]   prev_x, cur_x;
  logic [YW-1:0]   prev_y, cur_y;
  logic [XW:0]     x_next;
  logic            x_more, ch_more;
  logic            parse_done, eval_done;
  logic            line_req, line_done;
  logic [RW-1:0]   line_req_data;

`ifdef PLOT_SEQ_AXES_EN
  localparam logic [XW-1:0] AX_COL = XW'(AXIS_X);
  localparam logic [XW-1:0] X_MAX  = XW'(HOR_ACTIVE_PIXELS - 1);
  localparam logic [YW-1:0] AX_ROW = YW'(AXIS_Y);
  localparam logic [YW-1:0] Y_MAX  = YW'(VER_ACTIVE_PIXELS - 1);
  logic axis_sel;
`endif

  // Extra bit keeps the end-of-sweep test from wrapping.
  assign x_next     = {1'b0, eval_x} + X_INC;
  assign x_more     = (x_next <= X_LAST);
  assign ch_more    = (channel < CH_LAST);
  assign parse_done = !wait_arm && parser_ready;
  assign eval_done  = !wait_arm && eval_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
`ifdef PLOT_SEQ_AXES_EN
          state_nxt = S_AXES;
`else
          state_nxt = S_PARSE;
`endif
        end
`ifdef PLOT_SEQ_AXES_EN
        S_AXES:      state_nxt = S_AXES_WAIT;
        S_AXES_WAIT: if (line_done) state_nxt = axis_sel ? S_PARSE : S_AXES;
`endif
        S_PARSE:      state_nxt = S_PARSE_WAIT;
        S_PARSE_WAIT: if (parse_done) state_nxt = S_EVAL;
        S_EVAL:       state_nxt = S_EVAL_WAIT;
        S_EVAL_WAIT:  if (eval_done) state_nxt = (!eval_skip && have_prev) ? S_SEG : S_NEXT;
        S_SEG:        state_nxt = S_SEG_WAIT;
        S_SEG_WAIT:   if (line_done) state_nxt = S_NEXT;
        S_NEXT: begin
          if (x_more)       state_nxt = S_EVAL;
          else if (ch_more) state_nxt = S_PARSE;
          else              state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ready         = (state == S_IDLE);
    parser_start  = (state == S_PARSE);
    eval_start    = (state == S_EVAL);
    line_req      = (state == S_SEG);
    line_req_data = {prev_x, prev_y, cur_x, cur_y};
`ifdef PLOT_SEQ_AXES_EN
    if (state == S_AXES) begin
      line_req      = 1'b1;
      line_req_data = axis_sel ? {AX_COL, {YW{1'b0}}, AX_COL, Y_MAX}
                               : {{XW{1'b0}}, AX_ROW, X_MAX, AX_ROW};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      channel   <= '0;
      eval_x    <= '0;
      wait_arm  <= 1'b0;
      have_prev <= 1'b0;
      prev_x    <= '0;
      prev_y    <= '0;
      cur_x     <= '0;
      cur_y     <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) channel <= '0;
        S_PARSE, S_EVAL: wait_arm <= 1'b1;
        S_PARSE_WAIT: begin
          wait_arm <= 1'b0;
          if (parse_done) begin
            eval_x    <= '0;
            have_prev <= 1'b0;
          end
        end
        S_EVAL_WAIT: begin
          wait_arm <= 1'b0;
          if (eval_done) begin
            if (eval_skip) begin
              have_prev <= 1'b0;
            end else if (!have_prev) begin
              prev_x    <= eval_x;
              prev_y    <= eval_y;
              have_prev <= 1'b1;
            end else begin
              cur_x <= eval_x;
              cur_y <= eval_y;
            end
          end
        end
        // The issuer latches the old prev on this same edge.
        S_SEG: begin
          prev_x <= cur_x;
          prev_y <= cur_y;
        end
        S_NEXT: begin
          if (x_more)       eval_x  <= x_next[XW-1:0];
          else if (ch_more) channel <= channel + CW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef PLOT_SEQ_AXES_EN
  always_ff @(posedge clk) begin
    if (reset || abort)                          axis_sel <= 1'b0;
    else if (state == S_IDLE && start)           axis_sel <= 1'b0;
    else if (state == S_AXES_WAIT && line_done)  axis_sel <= 1'b1;
  end
`endif

  plot_line_issuer #(.XW(XW), .YW(YW)) u_line_issuer (
    .clk        (clk),
    .reset      (reset),
    .clear      (abort),
    .req        (line_req),
    .req_line   (line_req_data),
    .line_ready (line_ready),
    .line_start (line_start),
    .x1         (x1),
    .y1         (y1),
    .x2         (x2),
    .y2         (y2),
    .done       (line_done)
  );

endmodule
